br_pred_unit: RTL
=================

Name: br_pred_unit

Overview:
- Fetch-side branch predictor that sits directly upstream of the branch functional unit.
- Each fetched PC is looked up in a 256-entry BTB, a 256-entry local history table (LHT) and a 128-entry 2-bit pattern history table (PHT).
- The registered prediction (bp, bp_addr, lht_valid, lht_true) travels with the instruction into decode_info.
- The same structures are trained by the branch unit's resolution outputs (btb_web/btb_addr/btb_din/lht_in).

Parameters:
- BTB_IDX_BITS, 8, index width for BTB and LHT (entries = 2^8, index = pc[9:2]).
- PHT_IDX_BITS, 7, PHT index width (entries = 2^7).
- HIST_BITS, 8, local history width per LHT entry.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- fetch_valid  in  1  fetch PC valid this cycle
- fetch_pc  in  32  PC being fetched
- fetch_stall  in  1  hold current prediction outputs
- flush  in  1  pipeline redirect; kill pending prediction
- pred_valid  out  1  prediction outputs valid
- bp  out  1  predicted taken
- bp_addr  out  32  predicted next PC
- lht_valid  out  1  LHT entry for this PC has been trained
- lht_true  out  8  LHT history for this PC
- upd_valid  in  1  branch/jump resolved this cycle
- upd_pc  in  32  PC of the resolved instruction
- btb_web  in  1  active-low BTB write enable
- btb_addr  in  8  BTB write index
- btb_din  in  32  BTB write target
- lht_in  in  8  new history: [7:1] = old history[6:0], [0] = taken

Behaviour:
- Storage: btb_v[256], btb_tag[256] (22 b, pc[31:10]), btb_tgt[256] (32 b), lht_v[256], lht[256] (8 b), pht[128] (2 b counters). All storage is flops.
- Reset (rst low, async):
  - all btb_v and lht_v cleared; lht = 0; pht = 2'b01 (weakly not-taken).
  - outputs: pred_valid=0, bp=0, bp_addr=0, lht_valid=0, lht_true=0.
- Lookup: 1-cycle latency. Index i = fetch_pc[9:2]; PHT index p = lht[i][6:0] ^ fetch_pc[8:2].
  - hit = btb_v[i] && btb_tag[i]==fetch_pc[31:10].
  - Next cycle: bp = hit && pht[p][1]; bp_addr = bp ? btb_tgt[i] : fetch_pc+4 (32-bit wrap).
  - Next cycle: lht_valid = lht_v[i]; lht_true = lht[i]; pred_valid = fetch_valid.
- Stall: fetch_stall=1 holds all outputs and ignores fetch_pc. flush has priority over stall.
- Flush: next cycle pred_valid=0 and bp=0; other outputs don't-care. Training still occurs in a flush cycle.
- Training when upd_valid=1:
  - LHT: lht[upd_pc[9:2]] <= lht_in; lht_v <= 1.
  - PHT: q = lht_in[7:1] ^ upd_pc[8:2]. Counter saturating: lht_in[0]=1 increments (max 3), 0 decrements (min 0).
  - BTB: if btb_web=0, btb_v[btb_addr]<=1, btb_tag<=upd_pc[31:10], btb_tgt<=btb_din.
  - btb_web=0 with upd_valid=0 is ignored.
- Same-cycle read/write to the same entry: lookup uses the newly written value (write-first bypass) for BTB, LHT and the PHT counter whose index matches.
- BTB conflicts (same index, different tag) overwrite; there is no replacement state.
- Reset asserted mid-operation clears everything immediately; the first valid prediction appears one cycle after the first fetch_valid following reset release.

Optional Feature:
- BR_PRED_STATS_EN defined: adds outputs stat_lookups (32 b) and stat_taken_pred (32 b).
  - stat_lookups counts non-stalled fetch_valid cycles.
  - stat_taken_pred counts issued bp=1 predictions.
  - Both are cleared by reset and wrap at 2^32.
- Not defined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset, then fetch_pc=0x1000 -> next cycle pred_valid=1, bp=0, bp_addr=0x1004, lht_valid=0, lht_true=0.
- Train upd_pc=0x1000, btb_web=0, btb_addr=0x00, btb_din=0x2000, lht_in=0x01 twice (counter 01->10->11) -> lookup 0x1000 gives lht_valid=1, and bp=1 with bp_addr=0x2000 once the PHT entry at the lookup index reaches >=2.
- Tag mismatch: trained entry 0x1000, lookup 0x1400 (same index 0x00) -> bp=0, bp_addr=0x1404.
- Saturation: six not-taken updates on one PHT entry -> counter 0, bp=0. One taken update -> counter 1, bp remains 0.
- Same-cycle update and lookup of 0x3000 with btb_din=0x3100 and a taken-state counter -> next-cycle bp_addr=0x3100 (bypass).
- flush with fetch_stall simultaneously -> pred_valid=0 next cycle. Stall alone for 3 cycles -> outputs unchanged.

Source files
------------

// File: rtl/br_pred_unit.sv
// br_pred_unit -- fetch-side branch predictor.
//
// Each fetched PC is looked up in a direct-mapped BTB, a local history
// table (LHT) and a 2-bit saturating-counter pattern history table (PHT)
// indexed by local history XOR PC. The prediction is registered (1-cycle
// latency) and travels with the instruction. Resolution results from the
// branch unit train all three structures; a same-cycle lookup of an entry
// being trained sees the newly written value.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   fetch_valid/pc/stall  lookup request; stall holds the outputs
//   flush                 kill the pending prediction (beats stall)
//   pred_valid, bp, bp_addr, lht_valid, lht_true   registered prediction
//   upd_valid, upd_pc, btb_web, btb_addr, btb_din, lht_in   training
//
// Optional build macro BR_PRED_STATS_EN adds stat_lookups and
// stat_taken_pred counters as extra outputs.
module br_pred_unit #(
  parameter int unsigned BTB_IDX_BITS = 8,
  parameter int unsigned PHT_IDX_BITS = 7,
  parameter int unsigned HIST_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_valid,
  input  logic [31:0]             fetch_pc,
  input  logic                    fetch_stall,
  input  logic                    flush,
  output logic                    pred_valid,
  output logic                    bp,
  output logic [31:0]             bp_addr,
  output logic                    lht_valid,
  output logic [HIST_BITS-1:0]    lht_true,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic                    btb_web,
  input  logic [BTB_IDX_BITS-1:0] btb_addr,
  input  logic [31:0]             btb_din,
  input  logic [HIST_BITS-1:0]    lht_in
`ifdef BR_PRED_STATS_EN
  ,
  output logic [31:0]             stat_lookups,
  output logic [31:0]             stat_taken_pred
`endif
);

  localparam int unsigned BTB_N    = 1 << BTB_IDX_BITS;
  localparam int unsigned PHT_N    = 1 << PHT_IDX_BITS;
  localparam int unsigned TAG_BITS = 30 - BTB_IDX_BITS;

  logic                    r_btb_v   [BTB_N];
  logic [TAG_BITS-1:0]     r_btb_tag [BTB_N];
  logic [31:0]             r_btb_tgt [BTB_N];
  logic                    r_lht_v   [BTB_N];
  logic [HIST_BITS-1:0]    r_lht     [BTB_N];
  logic [1:0]              r_pht     [PHT_N];

  logic [BTB_IDX_BITS-1:0] w_idx;
  logic [BTB_IDX_BITS-1:0] w_upd_idx;
  logic                    w_btb_wr;
  logic [PHT_IDX_BITS-1:0] w_q;
  logic [1:0]              w_pht_cur;
  logic [1:0]              w_pht_new;
  logic                    w_lht_byp;
  logic                    w_btb_byp;
  logic                    w_lht_v_rd;
  logic [HIST_BITS-1:0]    w_lht_rd;
  logic                    w_btb_v_rd;
  logic [TAG_BITS-1:0]     w_btb_tag_rd;
  logic [31:0]             w_btb_tgt_rd;
  logic [PHT_IDX_BITS-1:0] w_p;
  logic [1:0]              w_ctr;
  logic                    w_hit;
  logic                    w_bp;
  logic [31:0]             w_bp_addr;
  logic                    w_unused_bits;

  assign w_unused_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Training side
  assign w_upd_idx = upd_pc[BTB_IDX_BITS+1:2];
  assign w_btb_wr  = upd_valid && !btb_web;
  assign w_q       = lht_in[PHT_IDX_BITS:1] ^ upd_pc[PHT_IDX_BITS+1:2];
  assign w_pht_cur = r_pht[w_q];
  assign w_pht_new = lht_in[0] ? ((w_pht_cur == 2'b11) ? 2'b11 : w_pht_cur + 2'd1)
                               : ((w_pht_cur == 2'b00) ? 2'b00 : w_pht_cur - 2'd1);

  // Lookup side with write-first bypass. The PHT index is formed from the
  // bypassed history, so a same-cycle LHT write also steers the PHT read.
  assign w_idx        = fetch_pc[BTB_IDX_BITS+1:2];
  assign w_lht_byp    = upd_valid && (w_upd_idx == w_idx);
  assign w_btb_byp    = w_btb_wr && (btb_addr == w_idx);
  assign w_lht_v_rd   = w_lht_byp ? 1'b1   : r_lht_v[w_idx];
  assign w_lht_rd     = w_lht_byp ? lht_in : r_lht[w_idx];
  assign w_btb_v_rd   = w_btb_byp ? 1'b1                : r_btb_v[w_idx];
  assign w_btb_tag_rd = w_btb_byp ? upd_pc[31:32-TAG_BITS] : r_btb_tag[w_idx];
  assign w_btb_tgt_rd = w_btb_byp ? btb_din             : r_btb_tgt[w_idx];
  assign w_p          = w_lht_rd[PHT_IDX_BITS-1:0] ^ fetch_pc[PHT_IDX_BITS+1:2];
  assign w_ctr        = (upd_valid && (w_q == w_p)) ? w_pht_new : r_pht[w_p];
  assign w_hit        = w_btb_v_rd && (w_btb_tag_rd == fetch_pc[31:32-TAG_BITS]);
  assign w_bp         = w_hit && w_ctr[1];
  assign w_bp_addr    = w_bp ? w_btb_tgt_rd : fetch_pc + 32'd4;

  // Valid bits, histories and counters (reset)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BTB_N; i++) begin
        r_btb_v[i[BTB_IDX_BITS-1:0]] <= 1'b0;
        r_lht_v[i[BTB_IDX_BITS-1:0]] <= 1'b0;
        r_lht[i[BTB_IDX_BITS-1:0]]   <= '0;
      end
      for (int unsigned j = 0; j < PHT_N; j++) begin
        r_pht[j[PHT_IDX_BITS-1:0]] <= 2'b01;
      end
    end else begin
      if (w_btb_wr) begin
        r_btb_v[btb_addr] <= 1'b1;
      end
      if (upd_valid) begin
        r_lht_v[w_upd_idx] <= 1'b1;
        r_lht[w_upd_idx]   <= lht_in;
        r_pht[w_q]         <= w_pht_new;
      end
    end
  end

  // BTB payload is qualified by r_btb_v, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[btb_addr] <= upd_pc[31:32-TAG_BITS];
      r_btb_tgt[btb_addr] <= btb_din;
    end
  end

  // Registered prediction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid <= 1'b0;
      bp         <= 1'b0;
      bp_addr    <= '0;
      lht_valid  <= 1'b0;
      lht_true   <= '0;
    end else if (flush) begin
      pred_valid <= 1'b0;
      bp         <= 1'b0;
    end else if (!fetch_stall) begin
      pred_valid <= fetch_valid;
      bp         <= w_bp;
      bp_addr    <= w_bp_addr;
      lht_valid  <= w_lht_v_rd;
      lht_true   <= w_lht_rd;
    end
  end

`ifdef BR_PRED_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups    <= '0;
      stat_taken_pred <= '0;
    end else begin
      if (fetch_valid && !fetch_stall) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (fetch_valid && !fetch_stall && !flush && w_bp) begin
        stat_taken_pred <= stat_taken_pred + 32'd1;
      end
    end
  end
`endif

endmodule
